time_keeper: RTL and testbench
==============================

TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter RESET_HOUR, default 12, SHALL set the hour loaded at reset; legal range 1..12.
REQ-002 Parameter RESET_PM, default 0, SHALL set the pm flag loaded at reset.
REQ-003 Port clk, input, 1, SHALL be the single system clock; all logic is rising-edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port enable_second, input, 1, SHALL carry a one-cycle tick per elapsed second.
REQ-006 Port btn_mode, input, 1, SHALL carry a debounced one-cycle mode-advance pulse.
REQ-007 Port btn_inc, input, 1, SHALL carry a debounced one-cycle increment pulse.
REQ-008 Port blink_in, input, 1, SHALL carry a square wave used for field blanking.
REQ-009 Port hours, output, 4, SHALL give the current hour, binary 1..12.
REQ-010 Port minutes, output, 6, SHALL give the current minute, binary 0..59.
REQ-011 Port seconds, output, 6, SHALL give the current second, binary 0..59.
REQ-012 Port pm, output, 1, SHALL be 1 for PM and 0 for AM.
REQ-013 Port mode, output, 2, SHALL encode the FSM state: 0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-014 Port blank_hours and blank_minutes, output, 1 each, SHALL request display blanking of that field.

Function
REQ-015 The FSM SHALL have states RUN, SET_HOUR and SET_MIN; btn_mode SHALL advance RUN->SET_HOUR->SET_MIN->RUN, one step per pulse.
REQ-016 In RUN, an enable_second pulse SHALL increment seconds, with the result visible on the next cycle.
REQ-017 When seconds is 59, a tick SHALL wrap seconds to 0 and increment minutes in the same cycle.
REQ-018 When minutes:seconds is 59:59, a tick SHALL wrap both to 0 and increment hours in the same cycle.
REQ-019 An hour increment from 11 SHALL give 12 and toggle pm; an increment from 12 SHALL give 1 with pm unchanged.
REQ-020 In SET_HOUR and SET_MIN, enable_second SHALL be ignored and seconds SHALL hold 0; seconds SHALL be forced to 0 on entry to SET_HOUR.
REQ-021 In SET_HOUR, btn_inc SHALL increment hours under REQ-019 rules, including the pm toggle.
REQ-022 In SET_MIN, btn_inc SHALL increment minutes with 59->0 wrap and no carry into hours.
REQ-023 In RUN, btn_inc SHALL have no effect.
REQ-024 When btn_mode and btn_inc are active in the same cycle, btn_mode SHALL win and btn_inc SHALL be discarded.
REQ-025 When btn_mode and enable_second are active in the same cycle in RUN, the FSM SHALL go to SET_HOUR and the tick SHALL be discarded.
REQ-026 On the SET_MIN->RUN transition, counting SHALL resume from seconds=0 on the next tick.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While reset is high, the block SHALL load hours=RESET_HOUR, minutes=0, seconds=0, pm=RESET_PM and mode=RUN, with blank_hours=blank_minutes=0.
REQ-029 Reset SHALL take priority over every other input in the same cycle, including during SET_HOUR or SET_MIN.

Configuration
REQ-030 With macro TIME_KEEPER_BLINK_EN defined:
- blank_hours SHALL equal ~blink_in (registered) in SET_HOUR, and 0 otherwise.
- blank_minutes SHALL equal ~blink_in (registered) in SET_MIN, and 0 otherwise.
REQ-031 Without TIME_KEEPER_BLINK_EN, both blank outputs SHALL be constant 0, blink_in SHALL be ignored, and the port list SHALL be unchanged.

Structure
REQ-032 Package time_keeper_pkg SHALL hold the FSM state typedef and the constants SEC_MAX=59, MIN_MAX=59, HOUR_MIN=1, HOUR_MAX=12 and HOUR_PM_EDGE=11.
REQ-033 The seconds and minutes fields SHALL each use one instance of sub-module mod60_counter (inputs clear and inc; outputs value and carry).

Verification
REQ-034 Reset, then one tick -> 12:00:01 AM, mode=0.
REQ-035 From 11:59:58 AM, two ticks -> 11:59:59 AM, then 12:00:00 PM.
REQ-036 From 12:59:59 PM, one tick -> 01:00:00 PM, pm unchanged.
REQ-037 btn_mode, then 3x btn_inc from hour 10 AM -> hour 1 PM; btn_mode, then 61x btn_inc from minute 0 -> minute 1, hour unchanged; btn_mode -> mode=0, seconds=0.
REQ-038 btn_mode together with enable_second in RUN -> mode=1, seconds=0, no increment; btn_mode together with btn_inc in SET_HOUR -> mode=2, hours unchanged.
REQ-039 Assert reset while in SET_MIN -> 12:00:00 AM, mode=0 on the next cycle; with TIME_KEEPER_BLINK_EN, blank_hours tracks ~blink_in only in SET_HOUR.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the 12-hour time keeper.
// Contents:
//   state_t      - set/run FSM state, values match the mode output encoding
//   SEC_MAX, MIN_MAX             - last value of the seconds/minutes fields
//   HOUR_MIN, HOUR_MAX           - hour range of the 12-hour display
//   HOUR_PM_EDGE                 - hour whose increment toggles am/pm
//   hour_next()  - 12-hour successor (12 -> 1)
package time_keeper_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [5:0] SEC_MAX      = 6'd59;
  localparam logic [5:0] MIN_MAX      = 6'd59;
  localparam logic [3:0] HOUR_MIN     = 4'd1;
  localparam logic [3:0] HOUR_MAX     = 4'd12;
  localparam logic [3:0] HOUR_PM_EDGE = 4'd11;

  function automatic logic [3:0] hour_next(input logic [3:0] h);
    return (h == HOUR_MAX) ? HOUR_MIN : h + 4'd1;
  endfunction

endpackage

// File: rtl/time_keeper_mod60.sv
// mod60_counter: registered 0..WRAP counter used for the seconds and minutes
// fields.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   clear       - synchronous clear to 0, overrides inc
//   inc         - advance by one, wrapping WRAP -> 0
//   value       - registered count
//   carry       - combinational, high when this inc wraps the counter
module mod60_counter
  import time_keeper_pkg::*;
#(
  parameter logic [5:0] WRAP = SEC_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [5:0] value,
  output logic       carry
);

  assign carry = inc && !clear && (value == WRAP);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + 6'd1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 12-hour clock with a three-state set/run FSM.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   enable_second     - one-cycle tick per elapsed second
//   btn_mode, btn_inc - debounced one-cycle button pulses
//   blink_in          - square wave for blanking the field being set
//   hours/minutes/seconds/pm - registered current time (hours 1..12)
//   mode              - 0=RUN, 1=SET_HOUR, 2=SET_MIN
//   blank_hours/blank_minutes - field blanking requests
// Build option: define TIME_KEEPER_BLINK_EN to drive the blank outputs from
// ~blink_in while the matching field is being set; otherwise they are 0 and
// blink_in is unused.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int unsigned RESET_HOUR = 12,
  parameter bit          RESET_PM   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_second,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       blink_in,
  output logic [3:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blank_hours,
  output logic       blank_minutes
);

  state_t state_q, state_d;
  logic   sec_clear, sec_inc, sec_carry;
  logic   min_inc, min_carry;
  logic   hour_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: one step per mode pulse
  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Field controls. A mode pulse swallows any tick or increment in the same
  // cycle; seconds are held at 0 throughout the set states and on entry.
  always_comb begin
    sec_clear = btn_mode || (state_q != RUN);
    sec_inc   = (state_q == RUN) && enable_second;
    min_inc   = ((state_q == RUN) && sec_carry) ||
                ((state_q == SET_MIN) && btn_inc && !btn_mode);
    hour_inc  = ((state_q == RUN) && min_carry) ||
                ((state_q == SET_HOUR) && btn_inc && !btn_mode);
  end

  mod60_counter #(.WRAP(SEC_MAX)) u_seconds (
    .clk   (clk),
    .reset (reset),
    .clear (sec_clear),
    .inc   (sec_inc),
    .value (seconds),
    .carry (sec_carry)
  );

  mod60_counter #(.WRAP(MIN_MAX)) u_minutes (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (min_inc),
    .value (minutes),
    .carry (min_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hours <= 4'(RESET_HOUR);
      pm    <= RESET_PM;
    end else if (hour_inc) begin
      hours <= hour_next(hours);
      if (hours == HOUR_PM_EDGE) pm <= ~pm;
    end
  end

  assign mode = state_q;

`ifdef TIME_KEEPER_BLINK_EN
  // Keyed on the next state so blanking lines up with the mode output.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_hours   <= 1'b0;
      blank_minutes <= 1'b0;
    end else begin
      blank_hours   <= (state_d == SET_HOUR) && !blink_in;
      blank_minutes <= (state_d == SET_MIN) && !blink_in;
    end
  end
`else
  logic unused_blink;
  assign unused_blink  = blink_in;
  assign blank_hours   = 1'b0;
  assign blank_minutes = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable_second = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       blink_in = 1'b0;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       pm;
  logic [1:0] mode;
  logic       blank_hours;
  logic       blank_minutes;

  int checks = 0;
  int passes = 0;

  // Reference model: time of day as seconds since midnight (24-hour), plus
  // a mode number 0..2. The 12-hour display is derived from it.
  int m_total = 0;
  int m_mode  = 0;
  bit exp_bh  = 1'b0;
  bit exp_bm  = 1'b0;

  time_keeper #(.RESET_HOUR(12), .RESET_PM(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable_second (enable_second),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .blink_in      (blink_in),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .pm            (pm),
    .mode          (mode),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [18:0] exp_vec();
    int h24 = m_total / 3600;
    int h12 = h24 % 12;
    if (h12 == 0) h12 = 12;
    return {4'(h12), 6'((m_total / 60) % 60), 6'(m_total % 60),
            1'(h24 >= 12), 2'(m_mode)};
  endfunction

  // Drive one cycle of inputs, then advance the model by the same cycle.
  task automatic step(input bit r, input bit m, input bit i, input bit t);
    bit bl;
    int mn;
    bl = 1'($urandom_range(0, 1));
    @(negedge clk);
    reset = r; btn_mode = m; btn_inc = i; enable_second = t; blink_in = bl;
    @(posedge clk);
    #1;
    if (r) begin
      m_total = 0;
      m_mode  = 0;
    end else if (m) begin
      m_mode = (m_mode + 1) % 3;
      if (m_mode == 1) m_total = m_total - (m_total % 60);
    end else if (m_mode == 0) begin
      if (t) m_total = (m_total + 1) % 86400;
    end else if (m_mode == 1) begin
      if (i) m_total = (m_total + 3600) % 86400;
    end else if (i) begin
      mn = (m_total / 60) % 60;
      m_total = m_total - mn * 60 + ((mn + 1) % 60) * 60;
    end
`ifdef TIME_KEEPER_BLINK_EN
    exp_bh = !r && (m_mode == 1) && !bl;
    exp_bm = !r && (m_mode == 2) && !bl;
`else
    exp_bh = 1'b0;
    exp_bm = 1'b0;
`endif
  endtask

  // Reset, then set the clock to h24:mn:00 through the set states.
  task automatic set_time(input int h24, input int mn);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (h24) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (mn) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm, mode, blank_hours, blank_minutes} !==
        {4'd12, 6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state got h=%0d m=%0d s=%0d pm=%0d mode=%0d bh=%0d bm=%0d exp 12:00:00 pm=0 mode=0 blank=0",
               hours, minutes, seconds, pm, mode, blank_hours, blank_minutes);
    end else passes++;
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm, mode} !== {4'd12, 6'd0, 6'd1, 1'b0, 2'd0}) begin
      $display("FAIL first_tick got %0d:%0d:%0d pm=%0d mode=%0d exp 12:00:01 pm=0 mode=0",
               hours, minutes, seconds, pm, mode);
    end else passes++;
  endtask

  task automatic test_rollover();
    set_time(11, 59);
    repeat (58) step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm} !== {4'd11, 6'd59, 6'd58, 1'b0}) begin
      $display("FAIL roll_start got %0d:%0d:%0d pm=%0d exp 11:59:58 pm=0", hours, minutes, seconds, pm);
    end else passes++;
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm} !== {4'd11, 6'd59, 6'd59, 1'b0}) begin
      $display("FAIL roll_5959 got %0d:%0d:%0d pm=%0d exp 11:59:59 pm=0", hours, minutes, seconds, pm);
    end else passes++;
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm} !== {4'd12, 6'd0, 6'd0, 1'b1}) begin
      $display("FAIL roll_noon got %0d:%0d:%0d pm=%0d exp 12:00:00 pm=1", hours, minutes, seconds, pm);
    end else passes++;
  endtask

  task automatic test_hour_wrap();
    set_time(12, 59);
    repeat (59) step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm} !== {4'd12, 6'd59, 6'd59, 1'b1}) begin
      $display("FAIL wrap_start got %0d:%0d:%0d pm=%0d exp 12:59:59 pm=1", hours, minutes, seconds, pm);
    end else passes++;
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, pm} !== {4'd1, 6'd0, 6'd0, 1'b1}) begin
      $display("FAIL wrap_12_to_1 got %0d:%0d:%0d pm=%0d exp 1:00:00 pm=1", hours, minutes, seconds, pm);
    end else passes++;
  endtask

  task automatic test_set_mode();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 1, 0);
    checks++;
    if ({hours, pm, mode} !== {4'd10, 1'b0, 2'd1}) begin
      $display("FAIL set_hour10 got h=%0d pm=%0d mode=%0d exp h=10 pm=0 mode=1", hours, pm, mode);
    end else passes++;
    repeat (3) step(0, 0, 1, 1);
    checks++;
    if ({hours, seconds, pm, mode} !== {4'd1, 6'd0, 1'b1, 2'd1}) begin
      $display("FAIL set_hour_pm got h=%0d s=%0d pm=%0d mode=%0d exp h=1 s=0 pm=1 mode=1", hours, seconds, pm, mode);
    end else passes++;
    step(0, 1, 0, 0);
    repeat (61) step(0, 0, 1, 0);
    checks++;
    if ({hours, minutes, pm, mode} !== {4'd1, 6'd1, 1'b1, 2'd2}) begin
      $display("FAIL set_min_wrap got h=%0d m=%0d pm=%0d mode=%0d exp h=1 m=1 pm=1 mode=2", hours, minutes, pm, mode);
    end else passes++;
    step(0, 1, 0, 0);
    checks++;
    if ({seconds, mode} !== {6'd0, 2'd0}) begin
      $display("FAIL set_exit got s=%0d mode=%0d exp s=0 mode=0", seconds, mode);
    end else passes++;
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds} !== {4'd1, 6'd1, 6'd1}) begin
      $display("FAIL resume got %0d:%0d:%0d exp 1:01:01", hours, minutes, seconds);
    end else passes++;
  endtask

  task automatic test_collisions();
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    checks++;
    if ({mode, seconds} !== {2'd1, 6'd0}) begin
      $display("FAIL mode_vs_tick got mode=%0d s=%0d exp mode=1 s=0", mode, seconds);
    end else passes++;
    step(0, 1, 1, 0);
    checks++;
    if ({mode, hours, pm} !== {2'd2, 4'd12, 1'b0}) begin
      $display("FAIL mode_vs_inc got mode=%0d h=%0d pm=%0d exp mode=2 h=12 pm=0", mode, hours, pm);
    end else passes++;
  endtask

  task automatic test_reset_in_set();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (7) step(0, 0, 1, 0);
    step(1, 1, 1, 1);
    checks++;
    if ({hours, minutes, seconds, pm, mode} !== {4'd12, 6'd0, 6'd0, 1'b0, 2'd0}) begin
      $display("FAIL reset_in_set got %0d:%0d:%0d pm=%0d mode=%0d exp 12:00:00 pm=0 mode=0",
               hours, minutes, seconds, pm, mode);
    end else passes++;
  endtask

  task automatic test_random();
    bit r, m, i, t;
    step(1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      m = ($urandom_range(0, 15) == 0);
      i = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 1) == 0);
      step(r, m, i, t);
      checks++;
      if ({hours, minutes, seconds, pm, mode} !== exp_vec()) begin
        $display("FAIL random_time cycle %0d got h/m/s/pm/mode=%h exp %h", n,
                 {hours, minutes, seconds, pm, mode}, exp_vec());
      end else passes++;
      checks++;
      if ({blank_hours, blank_minutes} !== {exp_bh, exp_bm}) begin
        $display("FAIL random_blank cycle %0d got bh=%0d bm=%0d exp bh=%0d bm=%0d", n,
                 blank_hours, blank_minutes, exp_bh, exp_bm);
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_hour_wrap();
    test_set_mode();
    test_collisions();
    test_reset_in_set();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
